seq_check_rx: RTL
=================

Name: seq_check_rx

Overview:
- Two-wire (rdy/ack) stream receiver and checker for counting-sequence stimulus driven by the cosim bench.
- Accepts NBEAT beats of DW-bit data after a start pulse and checks that each beat equals the previous beat + 1 (mod 2^DW), with the first expected value INIT.
- Reports error count, beat count and completion back to the bench.
- Optional periodic backpressure on ack exercises the transmitter side.

Parameters:
- DW, 4, data width.
- NBEAT, 10, beats per run (1..255).
- INIT, 0, expected value of the first beat.
- STALL_PERIOD, 0: ack is deasserted one cycle in every STALL_PERIOD cycles while receiving; 0 or 1 disables stalling.

Ports:
- clk  in  1  clock; all state changes on posedge clk.
- rst  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle start pulse.
- i_rdy  in  1  transmitter has valid data.
- i_dat  in  DW  transmitter data.
- o_ack  out  1  receiver accepts; a transfer occurs when i_rdy & o_ack are high at posedge clk.
- o_busy  out  1  high in RECV.
- o_done  out  1  high in DONE.
- o_err  out  1  sticky mismatch flag for the current run.
- o_err_cnt  out  8  mismatch count, saturates at 255.
- o_beat_cnt  out  8  transfers completed in the current run.
- o_last_dat  out  DW  data of the most recent transfer.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0.
  - Expected register is INIT; stall counter is 0.
- States: IDLE, RECV, DONE. Encoding is free.
- IDLE:
  - o_ack = 0.
  - i_start moves to RECV next cycle and clears err, err_cnt, beat_cnt and last_dat.
  - Expected register is set to INIT; stall counter is cleared.
- RECV:
  - o_ack is combinational from registered state only: 1, except when STALL_PERIOD >= 2 and the stall counter equals STALL_PERIOD-1.
  - o_ack never depends on i_rdy.
  - Stall counter increments every cycle in RECV, wrapping from STALL_PERIOD-1 to 0.
  - Transfer: last_dat <= i_dat and beat_cnt <= beat_cnt+1.
  - Mismatch (i_dat != expected): err <= 1 and err_cnt <= min(err_cnt+1, 255).
  - After every transfer, expected <= i_dat + 1 mod 2^DW. The checker resyncs to the received value, so a single corrupted beat counts as one error, not a cascade.
  - A transfer that makes beat_cnt reach NBEAT moves to DONE next cycle.
  - No transfer without i_rdy. i_rdy dropping mid-run is legal and only delays completion.
  - i_start in RECV is ignored.
- DONE:
  - o_ack = 0; o_done = 1.
  - Counters, err and last_dat hold for readback.
  - i_start restarts exactly as from IDLE: clears results and enters RECV next cycle.
- Wrap-around: INIT = 2^DW-1 expects 0 next; wrapping 15 -> 0 at DW=4 is not an error.
- Latency: o_err and o_err_cnt update the cycle after the offending transfer; o_done rises the cycle after the NBEAT-th transfer.
- Reset mid-run aborts immediately. There is no partial result retention.

Test Plan:
- DW=4, NBEAT=10, no stall: i_start, then i_rdy held with 0..9 on consecutive cycles -> ack high for 10 cycles, o_done the cycle after the 10th transfer, err_cnt=0, beat_cnt=10, last_dat=9.
- Wrap, NBEAT=20: data 0..15,0..3 -> o_done, err_cnt=0, last_dat=3.
- Glitch, NBEAT=6: data 0,1,2,7,8,9 -> err=1, err_cnt=1 (resync on 7); data 0,5,2,3,4,5 -> err_cnt=2.
- Backpressure, STALL_PERIOD=3, i_rdy held, data advanced only on transfer -> ack pattern 1,1,0 repeating, 10 beats complete in 14 cycles, err_cnt=0.
- Bursty rdy: i_rdy toggled 1,0 every cycle -> 10 transfers in 19 cycles, no errors, ack stays 1.
- Control:
  - i_start during RECV is ignored (beat_cnt continues).
  - rst pulsed low after 4 beats -> all outputs 0 and IDLE immediately.
  - A new i_start then runs cleanly to beat_cnt=10.
  - i_start in DONE clears err_cnt from 1 to 0.

Source files
------------

// File: rtl/seq_check_rx.sv
// seq_check_rx: rdy/ack stream receiver that checks a counting sequence.
// Each beat is expected to equal the previous beat + 1 (mod 2^DW).
// The first beat is expected to equal INIT.
// After a mismatch the checker resyncs to the received value, so one bad beat
// costs exactly one error.
module seq_check_rx #(
    parameter int DW           = 4,
    parameter int NBEAT        = 10,
    parameter int INIT         = 0,
    parameter int STALL_PERIOD = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_ack,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [7:0]    o_err_cnt,
    output logic [7:0]    o_beat_cnt,
    output logic [DW-1:0] o_last_dat
);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

    localparam bit          STALL_EN   = (STALL_PERIOD >= 2);
    localparam logic [15:0] STALL_LAST = 16'(STALL_PERIOD - 1);

    state_t          state, nstate;
    logic [15:0]     stall_cnt;
    logic [DW-1:0]   expd;
    logic            xfer;
    logic            last_beat;

    // o_ack is already 0 outside RECV, so this is the whole transfer condition.
    assign xfer      = o_ack & i_rdy;
    assign last_beat = (o_beat_cnt == 8'(NBEAT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= nstate;
    end

    // Next-state logic. DONE restarts exactly like IDLE. Start is ignored in RECV.
    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  if (i_start) nstate = S_RECV;
            S_RECV:  if (xfer && last_beat) nstate = S_DONE;
            S_DONE:  if (i_start) nstate = S_RECV;
            default: nstate = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state only. ack never looks at i_rdy.
    always_comb begin
        o_ack  = 1'b0;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (state)
            S_RECV: begin
                o_busy = 1'b1;
                o_ack  = !(STALL_EN && (stall_cnt == STALL_LAST));
            end
            S_DONE:  o_done = 1'b1;
            default: ;
        endcase
    end

    // Checker datapath: stall counter, expected value, result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            expd       <= DW'(INIT);
            o_err      <= 1'b0;
            o_err_cnt  <= '0;
            o_beat_cnt <= '0;
            o_last_dat <= '0;
        end else if (state != S_RECV) begin
            stall_cnt <= '0;
            expd      <= DW'(INIT);
            if (i_start) begin
                o_err      <= 1'b0;
                o_err_cnt  <= '0;
                o_beat_cnt <= '0;
                o_last_dat <= '0;
            end
        end else begin
            if (STALL_EN)
                stall_cnt <= (stall_cnt == STALL_LAST) ? '0 : stall_cnt + 16'd1;
            if (xfer) begin
                o_last_dat <= i_dat;
                o_beat_cnt <= o_beat_cnt + 8'd1;
                expd       <= i_dat + DW'(1);
                if (i_dat != expd) begin
                    o_err <= 1'b1;
                    if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
                end
            end
        end
    end

endmodule
